lfsr_seq_checker: RTL

//  Receive-side partner of the team's N-bit LFSR random-number generator.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_seq_checker_if.sv | 27 ++
 rtl/sat_counter.sv | 22 ++
 rtl/lfsr_seq_checker.sv | 108 ++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator / sequence checker pair.
// Holds the checker state type and the common feedback function.
package lfsr_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Widest register lfsr_next accepts; narrower registers are zero-extended.
    localparam int LFSR_MAX_W = 32;

    // Feedback bit of the Fibonacci LFSR: taps at msb and msb-1.
    function automatic logic lfsr_next(input logic [LFSR_MAX_W-1:0] s,
                                       input logic [4:0]            msb);
        return s[msb] ^ s[msb - 5'd1];
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Serial receive port of the PRBS checker plus its status outputs.
// in_valid qualifies in_bit for one cycle; the checker has no back-pressure and consumes every valid bit.
interface lfsr_seq_checker_if #(
    parameter int CNT_W = 16
);
    import lfsr_pkg::*;

    logic             in_bit;
    logic             in_valid;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;
    chk_state_t       state;

    modport master (
        output in_bit, in_valid, clr_err,
        input  locked, err_pulse, err_cnt, bit_cnt, state
    );

    modport slave (
        input  in_bit, in_valid, clr_err,
        output locked, err_pulse, err_cnt, bit_cnt, state
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising PRBS checker: loads a local LFSR from the line, then
// free-runs it and counts mispredicted bits while locked.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int N            = 13,   // LFSR width, at most LFSR_MAX_W
    parameter int LOCK_MATCHES = 16,
    parameter int UNLOCK_ERRS  = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    lfsr_seq_checker_if.slave  chk
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int XW = $clog2(UNLOCK_ERRS + 1);

    chk_state_t        state;
    logic [N-1:0]      s;
    logic [FW-1:0]     fill;
    logic [MW-1:0]     match_cnt;
    logic [XW-1:0]     miss_cnt;
    logic              err_q;

    logic pred;
    logic match;
    logic bit_inc;
    logic err_inc;

    assign pred    = lfsr_next(LFSR_MAX_W'(s), 5'(N - 1));
    assign match   = (chk.in_bit == pred);
    assign bit_inc = chk.in_valid && (state == LOCKED);
    assign err_inc = bit_inc && !match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            s         <= '0;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_inc;
            if (chk.in_valid) begin
                case (state)
                    SEARCH: begin
                        s <= {s[N-2:0], chk.in_bit};
                        if (fill != FW'(N)) begin
                            fill <= fill + FW'(1);
                        end else if (match && (s != '0)) begin
                            // An all-zero register predicts zeros forever; never lock on it.
                            if (match_cnt == MW'(LOCK_MATCHES - 1)) begin
                                state     <= LOCKED;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so line errors stay single-bit.
                        s <= {s[N-2:0], pred};
                        if (!match) begin
                            if (miss_cnt == XW'(UNLOCK_ERRS - 1)) begin
                                state     <= SEARCH;
                                fill      <= '0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + XW'(1);
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (chk.clr_err),
        .count (chk.err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bit_inc),
        .clr   (chk.clr_err),
        .count (chk.bit_cnt)
    );

    assign chk.locked    = (state == LOCKED);
    assign chk.err_pulse = err_q;
    assign chk.state     = state;

endmodule
